max_frame_ctrl: RTL and testbench
=================================

# max_frame_ctrl

Sequencing controller for the shared 4-bit combinational max comparator. It accepts a stream of unsigned samples over a valid/ready handshake and drives the comparator with the running maximum and the incoming sample each cycle. It tracks the frame maximum, the index of its first occurrence and the sample count, then presents the frame result on a second valid/ready handshake. It sits between a sample source and any consumer of per-frame peak values. The comparator stays a separate instance.

## Interface
- DATA_W, 4: sample width; must match the comparator width.
- FRAME_LEN, 8: samples per full frame; legal range 1 to 2^CNT_W − 1.
- CNT_W, 4: width of the index and count fields.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample present.
- in_ready  out  1  controller can accept a sample.
- in_data  in  DATA_W  unsigned sample.
- in_last  in  1  qualified by in_valid; the accepted sample ends the frame early.
- out_valid  out  1  frame result held.
- out_ready  in  1  consumer takes the result.
- out_max  out  DATA_W  frame maximum.
- out_index  out  CNT_W  zero-based index of the first sample equal to out_max.
- out_count  out  CNT_W  number of samples in the frame.
- cmp_x  out  DATA_W  to comparator x; running-max register.
- cmp_y  out  DATA_W  to comparator y; wired to in_data.
- cmp_max  in  DATA_W  from comparator.
  - Larger operand when the operands differ.
  - 0 when the operands are equal.

## Operation
- States:
  - IDLE: no frame open.
  - ACCUM: frame open, collecting samples.
  - HOLD: result presented.
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD.
- A sample is accepted when in_valid and in_ready are both 1.
- IDLE, sample accepted:
  - run_max ← in_data, run_idx ← 0, cnt ← 1. The comparator is not consulted.
  - If FRAME_LEN = 1 or in_last = 1, go to HOLD; otherwise go to ACCUM.
- ACCUM, sample accepted:
  - greater = (cmp_max == cmp_y) && (cmp_y != cmp_x).
  - If greater: run_max ← in_data, run_idx ← cnt.
  - On a tie (cmp_max = 0 from equality) or a smaller sample, run_max and run_idx keep their values, so the first occurrence wins.
  - cnt ← cnt + 1.
  - If cnt + 1 == FRAME_LEN or in_last = 1, go to HOLD.
- ACCUM, no sample accepted: all registers hold. There is no timeout.
- HOLD:
  - out_valid = 1.
  - out_max = run_max, out_index = run_idx, out_count = cnt.
  - in_valid is ignored.
  - On out_ready = 1, go to IDLE. The out_* outputs keep their last values; only out_valid drops.
- Outside HOLD, out_valid = 0.
- The out_* outputs come directly from registers. cmp_x = run_max in every state; its value is don't-care in IDLE.
- The comparator is combinational. A decision uses the cmp_max returned within the same cycle.
- in_last with cnt below FRAME_LEN − 1 closes a short frame. in_last on the FRAME_LEN-th sample has the same effect as a full frame.
- cnt never exceeds FRAME_LEN.

## Timing
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - run_max, run_idx, cnt = 0, so out_max = out_index = out_count = 0.
  - out_valid = 0.
  - Takes effect immediately, including mid-frame or in HOLD. A partial frame is discarded.
- Throughput is 1 sample per cycle inside a frame.
- Latency: out_valid rises on the clock edge that accepts the closing sample, so it is visible the next cycle.
- There is a minimum of 1 bubble cycle between frames: the HOLD cycle, in which in_ready = 0.
- Under backpressure, out_valid and the out_* outputs stay stable in HOLD until out_ready is sampled high.
- After the HOLD handshake, in_ready is 1 in the following cycle (IDLE).

## Test plan
- Full frame 3,7,2,7,1,0,5,6 at 1 sample/cycle, out_ready = 1 → out_valid for exactly 1 cycle, 1 cycle after the last accept; out_max = 7, out_index = 1 (tie at index 3 ignored), out_count = 8.
- Full frame of eight zeros → out_max = 0, out_index = 0, out_count = 8. Checks the equality case of the comparator's zero output.
- Early close: frame 9,4,12 with in_last on 12, then frame 15 with in_last on 15 → results (12, 2, 3) then (15, 0, 1).
- Backpressure:
  - Hold out_ready = 0 for 5 cycles in HOLD while in_valid = 1 and in_data toggles → in_ready = 0, the out_* outputs are unchanged and no sample is consumed.
  - After out_ready pulses, the next frame starts from the sample presented while in IDLE.
- Gapped input: in_valid deasserted every other cycle during frame 1,8,8,2,0,3,8,4 → results (8, 1, 8); no register changes on idle cycles.
- Reset mid-frame after 4 accepted samples, and again while in HOLD → all outputs 0 immediately. The next frame 5,5,5,5,5,5,5,6 gives (6, 7, 8) with no residue from the aborted frame.

Source files
------------

// File: rtl/max_frame_ctrl.sv
// max_frame_ctrl
//
// Purpose:
//   Sequencing controller for a shared combinational max comparator.
//   It accepts unsigned samples over a valid/ready handshake and tracks the
//   frame maximum, the index of its first occurrence, and the sample count.
//   The comparator sees the running maximum on x and the incoming sample on y.
//   When a frame closes, the controller presents the result on a second
//   valid/ready handshake. The comparator itself is instantiated elsewhere.
//
// Parameters:
//   DATA_W    - sample width; must match the comparator width
//   FRAME_LEN - samples per full frame (1 .. 2**CNT_W - 1)
//   CNT_W     - width of the index and count fields
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   sample present
//   in_ready  out  controller can accept a sample (low only while a result is held)
//   in_data   in   unsigned sample
//   in_last   in   accepted sample closes the frame early
//   out_valid out  frame result held
//   out_ready in   consumer takes the result
//   out_max   out  frame maximum
//   out_index out  zero-based index of the first sample equal to out_max
//   out_count out  number of samples in the frame
//   cmp_x     out  comparator operand x (running maximum register)
//   cmp_y     out  comparator operand y (incoming sample)
//   cmp_max   in   comparator result: larger operand, or 0 when operands are equal

module max_frame_ctrl #(
  parameter int DATA_W    = 4,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [CNT_W-1:0]  out_index,
  output logic [CNT_W-1:0]  out_count,
  output logic [DATA_W-1:0] cmp_x,
  output logic [DATA_W-1:0] cmp_y,
  input  logic [DATA_W-1:0] cmp_max
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   run_max;
  logic [DATA_W-1:0]   run_max_nxt;
  logic [CNT_W-1:0]    run_idx;
  logic [CNT_W-1:0]    run_idx_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [CNT_W-1:0]    cnt_inc;
  logic                accept;
  logic                greater;

  // Handshake and comparator wiring. The comparator returns 0 on equal
  // operands, so "cmp_max equals the new sample" alone would misread a tie
  // on a zero sample; the extra inequality term makes only a strictly larger
  // sample count as a new maximum, which keeps the first occurrence.
  assign in_ready = (state != HOLD);
  assign accept   = in_valid && in_ready;
  assign cmp_x    = run_max;
  assign cmp_y    = in_data;
  assign greater  = (cmp_max == cmp_y) && (cmp_y != cmp_x);
  assign cnt_inc  = cnt + ONE_C;

  // The result fields are the running registers themselves, so they stay
  // put after the result handshake until the next frame opens.
  assign out_valid = (state == HOLD);
  assign out_max   = run_max;
  assign out_index = run_idx;
  assign out_count = cnt;

  // Next-state and datapath update. A frame opens on the first accepted
  // sample without consulting the comparator, then each further accepted
  // sample bumps the count and may replace the running maximum. The frame
  // closes on in_last or when the count reaches FRAME_LEN.
  always_comb begin
    state_nxt   = state;
    run_max_nxt = run_max;
    run_idx_nxt = run_idx;
    cnt_nxt     = cnt;

    case (state)
      IDLE: begin
        if (accept) begin
          run_max_nxt = in_data;
          run_idx_nxt = '0;
          cnt_nxt     = ONE_C;
          if ((FRAME_LEN == 1) || in_last) begin
            state_nxt = HOLD;
          end else begin
            state_nxt = ACCUM;
          end
        end
      end

      ACCUM: begin
        if (accept) begin
          if (greater) begin
            run_max_nxt = in_data;
            run_idx_nxt = cnt;
          end
          cnt_nxt = cnt_inc;
          if ((cnt_inc == FRAME_LEN_C) || in_last) begin
            state_nxt = HOLD;
          end
        end
      end

      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register. An asynchronous reset drops any open or held frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Running maximum, first-occurrence index and sample count. These
  // registers drive the result outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_max <= '0;
      run_idx <= '0;
      cnt     <= '0;
    end else begin
      run_max <= run_max_nxt;
      run_idx <= run_idx_nxt;
      cnt     <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_max_frame_ctrl.sv
// tb_max_frame_ctrl
//
// Purpose:
//   Self-checking bench for max_frame_ctrl. It models the external comparator,
//   drives directed and random sample streams, and checks frame results
//   against a reference model. The model works on whole frames held in a
//   queue.

module tb_max_frame_ctrl;

  localparam int DATA_W    = 4;
  localparam int FRAME_LEN = 8;
  localparam int CNT_W     = 4;

  typedef struct packed {
    logic [DATA_W-1:0] mx;
    logic [CNT_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt;
  } result_t;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_max;
  logic [CNT_W-1:0]  out_index;
  logic [CNT_W-1:0]  out_count;
  logic [DATA_W-1:0] cmp_x;
  logic [DATA_W-1:0] cmp_y;
  logic [DATA_W-1:0] cmp_max;

  result_t           expQ[$];
  logic [DATA_W-1:0] frameBuf[$];
  int                checks;
  int                errors;
  bit                randReady;
  bit                heldPrev;

  max_frame_ctrl #(
    .DATA_W(DATA_W),
    .FRAME_LEN(FRAME_LEN),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_max(out_max),
    .out_index(out_index),
    .out_count(out_count),
    .cmp_x(cmp_x),
    .cmp_y(cmp_y),
    .cmp_max(cmp_max)
  );

  // External comparator: the larger operand, or zero when the operands are equal.
  assign cmp_max = (cmp_x == cmp_y) ? '0 : ((cmp_x > cmp_y) ? cmp_x : cmp_y);

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Random consumer backpressure, active only while the random phase runs.
  always @(negedge clk) begin
    if (randReady) out_ready = ($urandom_range(0, 99) < 60);
  end

  // Counts one comparison and reports it when it fails.
  function automatic void checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endfunction

  // Reference model: the maximum of the frame, the first position holding it,
  // and the number of samples.
  function automatic void closeFrame();
    result_t r;
    r.mx  = frameBuf[0];
    r.idx = '0;
    for (int i = 1; i < frameBuf.size(); i++) begin
      if (frameBuf[i] > r.mx) begin
        r.mx  = frameBuf[i];
        r.idx = CNT_W'(i);
      end
    end
    r.cnt = CNT_W'(frameBuf.size());
    expQ.push_back(r);
    frameBuf.delete();
  endfunction

  // Records one accepted sample. Returns 1 when that sample closes the frame.
  function automatic bit modelAccept(logic [DATA_W-1:0] d, logic l);
    frameBuf.push_back(d);
    if (l || (frameBuf.size() == FRAME_LEN)) begin
      closeFrame();
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Maximum of the partial frame seen so far.
  function automatic logic [DATA_W-1:0] runningMax();
    logic [DATA_W-1:0] m;
    m = '0;
    foreach (frameBuf[i]) if (frameBuf[i] > m) m = frameBuf[i];
    return m;
  endfunction

  // Presents one sample and holds it until the controller accepts it. If the
  // sample closes a frame, the result must appear in the following cycle.
  task automatic sendSample(input logic [DATA_W-1:0] d, input logic l);
    int waited;
    bit closed;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    #1;
    checkOutput("cmp_y_follows_in_data", cmp_y, d);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for %0d cycles, want 1", waited);
    end else begin
      closed = modelAccept(d, l);
      @(negedge clk);
      if (closed) begin
        #1;
        checkOutput("out_valid_latency", out_valid, 1);
      end
    end
  endtask

  // One cycle with no sample. The running maximum on cmp_x must hold.
  task automatic idleCycle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    if (frameBuf.size() > 0) checkOutput("cmp_x_hold_on_gap", cmp_x, runningMax());
    @(negedge clk);
  endtask

  // Drops in_valid after a burst of samples.
  task automatic endBurst();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Sends up to eight samples packed low nibble first. The last sample can
  // optionally carry in_last, and the burst can be gapped.
  task automatic applyStimulus(input logic [31:0] packedData, input int len,
                               input bit lastAtEnd, input bit gapped);
    for (int i = 0; i < len; i++) begin
      sendSample(packedData[i*4 +: 4], lastAtEnd && (i == len - 1));
      if (gapped && (i != len - 1)) idleCycle();
    end
    endBurst();
  endtask

  // Asserts reset in mid-cycle and checks that the outputs clear at once,
  // then discards whatever the model had pending.
  task automatic resetPulse(input string tag);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_out_max"},   out_max,   0);
    checkOutput({tag, "_out_index"}, out_index, 0);
    checkOutput({tag, "_out_count"}, out_count, 0);
    checkOutput({tag, "_in_ready"},  in_ready,  1);
    frameBuf.delete();
    expQ.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor. While a result is held, it checks the result against the head
  // of the expected queue and checks that in_ready is low. It pops the queue
  // when the consumer takes the result. After a cycle under backpressure,
  // out_valid must still be high.
  initial begin
    result_t e;
    heldPrev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        heldPrev = 1'b0;
      end else begin
        if (heldPrev) checkOutput("out_valid_stable", out_valid, 1);
        if (out_valid) begin
          checkOutput("in_ready_low_in_hold", in_ready, 0);
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_result: got out_valid=1 max=%0d, want no result",
                     out_max);
          end else begin
            e = expQ[0];
            checkOutput("out_max",   out_max,   e.mx);
            checkOutput("out_index", out_index, e.idx);
            checkOutput("out_count", out_count, e.cnt);
            if (out_ready) void'(expQ.pop_front());
          end
          heldPrev = !out_ready;
        end else begin
          heldPrev = 1'b0;
        end
      end
    end
  end

  // Watchdog. It stops the run if the stimulus never completes.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no completion by time %0t, want completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence: directed cases from the test plan, then a
  // random phase, then a drain of outstanding results.
  initial begin
    int waited;
    checks    = 0;
    errors    = 0;
    randReady = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_max",   out_max,   0);
    checkOutput("reset_out_index", out_index, 0);
    checkOutput("reset_out_count", out_count, 0);
    checkOutput("reset_in_ready",  in_ready,  1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    $display("[TB] full frame with a tie");
    applyStimulus(32'h6501_7273, 8, 1'b0, 1'b0);

    $display("[TB] all-zero frame");
    applyStimulus(32'h0000_0000, 8, 1'b0, 1'b0);

    $display("[TB] early close frames");
    applyStimulus(32'h0000_0C49, 3, 1'b1, 1'b0);
    applyStimulus(32'h0000_000F, 1, 1'b1, 1'b0);

    $display("[TB] backpressure in hold");
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(32'h3142_5926, 8, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_last  = 1'b0;
      in_data  = (k % 2 == 0) ? 4'hA : 4'h5;
      #1;
      checkOutput("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_data   = 4'hE;
    @(negedge clk);
    #1;
    checkOutput("post_hold_in_ready", in_ready, 1);
    applyStimulus(32'h0000_1992, 4, 1'b1, 1'b0);

    $display("[TB] gapped input");
    applyStimulus(32'h4830_2881, 8, 1'b0, 1'b1);

    $display("[TB] reset mid-frame and in hold");
    @(negedge clk);
    applyStimulus(32'h0000_9D7B, 4, 1'b0, 1'b0);
    resetPulse("rst_midframe");
    out_ready = 1'b0;
    applyStimulus(32'h7777_7A77, 8, 1'b0, 1'b0);
    idleCycle();
    resetPulse("rst_hold");
    out_ready = 1'b1;
    applyStimulus(32'h6555_5555, 8, 1'b0, 1'b0);

    $display("[TB] random phase");
    randReady = 1'b1;
    for (int n = 0; n < 300; n++) begin
      sendSample((n % 3 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 9) < 3) idleCycle();
    end
    endBurst();

    // Drain: stop backpressure and let the monitor consume what is left.
    @(negedge clk);
    randReady = 1'b0;
    out_ready = 1'b1;
    waited    = 0;
    while (expQ.size() > 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
